execute_cycle: RTL and testbench

- Execute (EX) stage of the 5-stage RISC-V pipeline core.
- Consumes the ID/EX bundle produced by decode_cycle (control, RD1_E/RD2_E, Imm_Ext_E, RS1_E/RS2_E/RD_E, PCE/PCPlus4E) and applies operand forwarding.
- Performs the ALU operation, resolves branches, computes the branch target, and registers results into the EX/MEM pipeline register consumed by the memory stage.

---
 rtl/execute_cycle_if.sv | 53 +++++
 rtl/execute_cycle.sv | 99 +++++++++
 tb/tb_execute_cycle.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_cycle_if.sv
// rtl/execute_cycle_if.sv - ID/EX input bundle and EX/MEM output bundle of the execute stage
interface execute_cycle_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    // ID/EX bundle and forwarding controls
    logic              RegWriteE;
    logic              ALUSrcE;
    logic              MemWriteE;
    logic              ResultSrcE;
    logic              BranchE;
    logic [2:0]        ALUControlE;
    logic [DATA_W-1:0] RD1_E;
    logic [DATA_W-1:0] RD2_E;
    logic [DATA_W-1:0] Imm_Ext_E;
    logic [REG_AW-1:0] RS1_E;
    logic [REG_AW-1:0] RS2_E;
    logic [REG_AW-1:0] RD_E;
    logic [DATA_W-1:0] PCE;
    logic [DATA_W-1:0] PCPlus4E;
    logic [1:0]        ForwardA_E;
    logic [1:0]        ForwardB_E;
    logic [DATA_W-1:0] ResultW;

    // branch resolution, EX/MEM register and hazard-unit taps
    logic              PCSrcE;
    logic [DATA_W-1:0] PCTargetE;
    logic              RegWriteM;
    logic              MemWriteM;
    logic              ResultSrcM;
    logic [REG_AW-1:0] RD_M;
    logic [DATA_W-1:0] ALUResultM;
    logic [DATA_W-1:0] WriteDataM;
    logic [DATA_W-1:0] PCPlus4M;
    logic [REG_AW-1:0] RS1_H;
    logic [REG_AW-1:0] RS2_H;

    modport master (
        output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E,
               ForwardA_E, ForwardB_E, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALUResultM, WriteDataM, PCPlus4M, RS1_H, RS2_H
    );

    modport slave (
        input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E,
               ForwardA_E, ForwardB_E, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALUResultM, WriteDataM, PCPlus4M, RS1_H, RS2_H
    );
endinterface

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - RISC-V EX stage: forwarding, ALU, branch resolution, EX/MEM register
module execute_cycle #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic           clk,
    input logic           rst,
    execute_cycle_if.slave bus
);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic              reg_write_m;
    logic              mem_write_m;
    logic              result_src_m;
    logic [REG_AW-1:0] rd_m;
    logic [DATA_W-1:0] alu_result_m;
    logic [DATA_W-1:0] write_data_m;
    logic [DATA_W-1:0] pc_plus4_m;

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic              slt_lt;

    // Forward select 10 feeds back our own EX/MEM result; 11 falls back to the register file.
    always_comb begin
        src_a = bus.RD1_E;
        case (bus.ForwardA_E)
            2'b01:   src_a = bus.ResultW;
            2'b10:   src_a = alu_result_m;
            default: src_a = bus.RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = bus.RD2_E;
        case (bus.ForwardB_E)
            2'b01:   fwd_b = bus.ResultW;
            2'b10:   fwd_b = alu_result_m;
            default: fwd_b = bus.RD2_E;
        endcase
    end

    assign src_b  = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
    assign slt_lt = $signed(src_a) < $signed(src_b);

    always_comb begin
        alu_result = '0;
        case (bus.ALUControlE)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, slt_lt};
            default: alu_result = '0;
        endcase
    end

    // Branch outputs are purely combinational and intentionally not gated by reset.
    assign bus.PCSrcE    = bus.BranchE & (alu_result == '0);
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 1'b0;
            rd_m         <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
        end else begin
            reg_write_m  <= bus.RegWriteE;
            mem_write_m  <= bus.MemWriteE;
            result_src_m <= bus.ResultSrcE;
            rd_m         <= bus.RD_E;
            alu_result_m <= alu_result;
            write_data_m <= fwd_b;
            pc_plus4_m   <= bus.PCPlus4E;
        end
    end

    assign bus.RegWriteM  = reg_write_m;
    assign bus.MemWriteM  = mem_write_m;
    assign bus.ResultSrcM = result_src_m;
    assign bus.RD_M       = rd_m;
    assign bus.ALUResultM = alu_result_m;
    assign bus.WriteDataM = write_data_m;
    assign bus.PCPlus4M   = pc_plus4_m;
    assign bus.RS1_H      = bus.RS1_E;
    assign bus.RS2_H      = bus.RS2_E;
endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - scoreboard bench for the execute stage
module tb_execute_cycle;
    logic clk;
    logic rst;
    int   checks;
    int   passed;

    typedef struct packed {
        logic        regw;
        logic        memw;
        logic        rsrc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    exp_t act;
    exp_t exp_v;

    execute_cycle_if #(.DATA_W(32), .REG_AW(5)) bus ();

    execute_cycle #(.DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t m_now();
        m_now = {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M,
                 bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M};
    endfunction

    task automatic push_exp(input logic regw, input logic memw, input logic rsrc,
                            input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] wd, input logic [31:0] pc4);
        exp_t e;
        e = {regw, memw, rsrc, rd, alu, wd, pc4};
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        bus.RegWriteE   = 1'b0;
        bus.ALUSrcE     = 1'b0;
        bus.MemWriteE   = 1'b0;
        bus.ResultSrcE  = 1'b0;
        bus.BranchE     = 1'b0;
        bus.ALUControlE = 3'b000;
        bus.RD1_E       = '0;
        bus.RD2_E       = '0;
        bus.Imm_Ext_E   = '0;
        bus.RS1_E       = '0;
        bus.RS2_E       = '0;
        bus.RD_E        = '0;
        bus.PCE         = '0;
        bus.PCPlus4E    = '0;
        bus.ForwardA_E  = 2'b00;
        bus.ForwardB_E  = 2'b00;
        bus.ResultW     = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.RegWriteE   = 1'b1;
        bus.ALUSrcE     = 1'b1;
        bus.MemWriteE   = 1'b1;
        bus.ResultSrcE  = 1'b1;
        bus.BranchE     = 1'b1;
        bus.ALUControlE = 3'b011;
        bus.RD1_E       = 32'h1111_1111;
        bus.RD2_E       = 32'h2222_2222;
        bus.Imm_Ext_E   = 32'h3333_3333;
        bus.RS1_E       = 5'd7;
        bus.RS2_E       = 5'd9;
        bus.RD_E        = 5'd3;
        bus.PCE         = 32'h40;
        bus.PCPlus4E    = 32'h44;
        bus.ForwardA_E  = 2'b01;
        bus.ForwardB_E  = 2'b01;
        bus.ResultW     = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
            @(posedge clk); #1;
            act = m_now(); exp_v = exp_q.pop_front();
            checks++;
            if (act !== exp_v) $display("FAIL reset_m_outputs[%0d]: got %h required %h", i, act, exp_v);
            else passed++;
        end
        checks++;
        if ({bus.RS1_H, bus.RS2_H} !== {5'd7, 5'd9})
            $display("FAIL rs_passthrough: got %h/%h required 07/09", bus.RS1_H, bus.RS2_H);
        else passed++;
        rst = 1'b1;
        clear_inputs();
    endtask

    task automatic test_add_imm();
        bus.RegWriteE = 1'b1;
        bus.ALUSrcE   = 1'b1;
        bus.RD1_E     = 32'h10;
        bus.RD2_E     = 32'h55;
        bus.Imm_Ext_E = 32'hFFFF_FFFC;
        bus.RD_E      = 5'd5;
        bus.PCPlus4E  = 32'h44;
        #1;
        checks++;
        if (bus.PCSrcE !== 1'b0) $display("FAIL add_pcsrc: got %b required 0", bus.PCSrcE);
        else passed++;
        push_exp(1'b1, 1'b0, 1'b0, 5'd5, 32'h0C, 32'h55, 32'h44);
        @(posedge clk); #1;
        act = m_now(); exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) $display("FAIL add_imm: got %h required %h", act, exp_v);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_branch();
        bus.BranchE     = 1'b1;
        bus.ALUControlE = 3'b001;
        bus.RD1_E       = 32'h1234;
        bus.RD2_E       = 32'h1234;
        bus.PCE         = 32'h100;
        bus.Imm_Ext_E   = 32'hFFFF_FFF0;
        #1;
        checks++;
        if ({bus.PCSrcE, bus.PCTargetE} !== {1'b1, 32'hF0})
            $display("FAIL beq_taken: got %b/%h required 1/000000f0", bus.PCSrcE, bus.PCTargetE);
        else passed++;
        bus.RD2_E = 32'h1235;
        #1;
        checks++;
        if (bus.PCSrcE !== 1'b0) $display("FAIL beq_not_taken: got %b required 0", bus.PCSrcE);
        else passed++;
        bus.PCE       = 32'hFFFF_FFF0;
        bus.Imm_Ext_E = 32'h20;
        #1;
        checks++;
        if (bus.PCTargetE !== 32'h10) $display("FAIL target_wrap: got %h required 00000010", bus.PCTargetE);
        else passed++;
        bus.PCPlus4E = 32'h104;
        push_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h1235, 32'h104);
        @(posedge clk); #1;
        act = m_now(); exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) $display("FAIL beq_capture: got %h required %h", act, exp_v);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        // add x1 = 3 + 4
        bus.RegWriteE = 1'b1; bus.RD_E = 5'd1; bus.RD1_E = 32'd3; bus.RD2_E = 32'd4;
        push_exp(1'b1, 1'b0, 1'b0, 5'd1, 32'd7, 32'd4, 32'h0);
        @(posedge clk); #1;
        act = m_now(); exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) $display("FAIL b2b_producer: got %h required %h", act, exp_v);
        else passed++;
        // forward from M
        bus.ForwardA_E = 2'b10; bus.RD1_E = 32'd0; bus.RD2_E = 32'd0;
        bus.ALUSrcE = 1'b1; bus.Imm_Ext_E = 32'd1; bus.RD_E = 5'd2;
        push_exp(1'b1, 1'b0, 1'b0, 5'd2, 32'd8, 32'd0, 32'h0);
        @(posedge clk); #1;
        act = m_now(); exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) $display("FAIL b2b_fwd_m: got %h required %h", act, exp_v);
        else passed++;
        // forward from W
        bus.ForwardA_E = 2'b01; bus.ResultW = 32'h20;
        push_exp(1'b1, 1'b0, 1'b0, 5'd2, 32'h21, 32'd0, 32'h0);
        @(posedge clk); #1;
        act = m_now(); exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) $display("FAIL b2b_fwd_w: got %h required %h", act, exp_v);
        else passed++;
        // store data forwarded from M, immediate must not leak into write data
        bus.RegWriteE = 1'b0; bus.MemWriteE = 1'b1; bus.ForwardA_E = 2'b00;
        bus.ForwardB_E = 2'b10; bus.Imm_Ext_E = 32'd0; bus.RD_E = 5'd0;
        push_exp(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'h21, 32'h0);
        @(posedge clk); #1;
        act = m_now(); exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) $display("FAIL b2b_fwd_b_m: got %h required %h", act, exp_v);
        else passed++;
        // select 11 behaves like 00
        bus.MemWriteE = 1'b0; bus.RegWriteE = 1'b1; bus.ForwardA_E = 2'b11; bus.ForwardB_E = 2'b11;
        bus.RD1_E = 32'd9; bus.RD2_E = 32'h66; bus.ResultW = 32'h77; bus.Imm_Ext_E = 32'd1; bus.RD_E = 5'd4;
        push_exp(1'b1, 1'b0, 1'b0, 5'd4, 32'd10, 32'h66, 32'h0);
        @(posedge clk); #1;
        act = m_now(); exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) $display("FAIL fwd_sel_11: got %h required %h", act, exp_v);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_store();
        bus.MemWriteE = 1'b1; bus.ALUSrcE = 1'b1; bus.ForwardB_E = 2'b01;
        bus.ResultW = 32'hDEAD_BEEF; bus.RD2_E = 32'h0; bus.RD1_E = 32'h200;
        bus.Imm_Ext_E = 32'h8; bus.ResultSrcE = 1'b1; bus.PCPlus4E = 32'h88;
        push_exp(1'b0, 1'b1, 1'b1, 5'd0, 32'h208, 32'hDEAD_BEEF, 32'h88);
        @(posedge clk); #1;
        act = m_now(); exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) $display("FAIL store: got %h required %h", act, exp_v);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_alu_ops();
        logic [2:0]  ops [7];
        logic [31:0] a   [7];
        logic [31:0] b   [7];
        logic [31:0] res [7];
        ops[0] = 3'b101; a[0] = 32'hFFFF_FFFF; b[0] = 32'd1;         res[0] = 32'd1;
        ops[1] = 3'b101; a[1] = 32'd1;         b[1] = 32'hFFFF_FFFF; res[1] = 32'd0;
        ops[2] = 3'b111; a[2] = 32'd5;         b[2] = 32'd6;         res[2] = 32'd0;
        ops[3] = 3'b110; a[3] = 32'd5;         b[3] = 32'd6;         res[3] = 32'd0;
        ops[4] = 3'b010; a[4] = 32'hF0F0_1234; b[4] = 32'h0FF0_4321; res[4] = 32'h00F0_0220;
        ops[5] = 3'b011; a[5] = 32'hF0F0_1234; b[5] = 32'h0FF0_4321; res[5] = 32'hFFF0_5335;
        ops[6] = 3'b100; a[6] = 32'hF0F0_1234; b[6] = 32'h0FF0_4321; res[6] = 32'hFF00_5115;
        for (int i = 0; i < 7; i++) begin
            bus.ALUControlE = ops[i]; bus.RD1_E = a[i]; bus.RD2_E = b[i];
            bus.RD_E = 5'(i + 8); bus.RegWriteE = 1'b1;
            push_exp(1'b1, 1'b0, 1'b0, 5'(i + 8), res[i], b[i], 32'h0);
        end
        for (int i = 0; i < 7; i++) begin
            bus.ALUControlE = ops[i]; bus.RD1_E = a[i]; bus.RD2_E = b[i]; bus.RD_E = 5'(i + 8);
            @(posedge clk); #1;
            act = m_now(); exp_v = exp_q.pop_front();
            checks++;
            if (act !== exp_v) $display("FAIL alu_op_%b[%0d]: got %h required %h", ops[i], i, act, exp_v);
            else passed++;
        end
        clear_inputs();
    endtask

    task automatic test_reset_midstream();
        bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1; bus.RD1_E = 32'h1234; bus.RD2_E = 32'h1234;
        bus.ALUControlE = 3'b001; bus.BranchE = 1'b1; bus.RD_E = 5'd6; bus.PCPlus4E = 32'h10;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.PCSrcE !== 1'b1) $display("FAIL pcsrc_in_reset: got %b required 1", bus.PCSrcE);
        else passed++;
        push_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        act = m_now(); exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) $display("FAIL reset_discard: got %h required %h", act, exp_v);
        else passed++;
        rst = 1'b1;
        clear_inputs();
        bus.ForwardA_E = 2'b10; bus.ALUSrcE = 1'b1; bus.Imm_Ext_E = 32'd5;
        push_exp(1'b0, 1'b0, 1'b0, 5'd0, 32'd5, 32'd0, 32'h0);
        @(posedge clk); #1;
        act = m_now(); exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) $display("FAIL fwd_after_reset: got %h required %h", act, exp_v);
        else passed++;
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_add_imm();
        test_branch();
        test_back_to_back();
        test_store();
        test_alu_ops();
        test_reset_midstream();
        checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
